// File: rtl/cmul_pkg.sv
// Shared constants, types and the saturating round/shift helper for the complex multiplier.
// The helper works in a 64-bit container so one function serves every W up to 31.
package cmul_pkg;

  localparam int CMUL_LAT = 4;
  localparam int CPLX_W   = 20;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_t;

  // Scale a Q2.(2w-2) sum back to Q1.(w-1): optional half-up round, arithmetic shift, clamp.
  function automatic sat_t sat_round_fn(input logic signed [63:0] sum, input int w, input bit rnd);
    sat_t               r;
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (rnd) v = (sum + (64'sd1 <<< (w - 2))) >>> (w - 1);
    else     v = sum >>> (w - 1);
    r.ovf = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmul_pipe_sat_round.sv
// Combinational scale/round/clamp of one (2W+1)-bit component to W bits plus its overflow bit.
module sat_round
  import cmul_pkg::*;
#(
  parameter int W   = 20,
  parameter bit RND = 1'b1
) (
  input  logic signed [2*W:0] i_sum,
  output logic signed [W-1:0] o_val,
  output logic                o_ovf
);

  sat_t w_res;
  logic w_unused_hi;

  always_comb begin
    w_res = sat_round_fn({{(63-2*W){i_sum[2*W]}}, i_sum}, W, RND);
  end

  assign o_val       = w_res.val[W-1:0];
  assign o_ovf       = w_res.ovf;
  // Upper bits only ever hold the sign once clamped.
  assign w_unused_hi = ^w_res.val[63:W];

endmodule

// File: rtl/cmul_pipe.sv
// Fully pipelined signed Q1.(W-1) complex multiplier, optional conj(b), round/saturate, sticky ovf.
// Fixed CMUL_LAT-cycle latency with a registered output stage; one sample per cycle, no backpressure.
module cmul_pipe
  import cmul_pkg::*;
#(
  parameter int W    = 20,
  parameter int TAGW = 8,
  parameter bit RND  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   operation_nd,
  output logic                   operation_rfd,
  input  logic                   conj_b,
  input  logic signed [W-1:0]    a_re,
  input  logic signed [W-1:0]    a_im,
  input  logic signed [W-1:0]    b_re,
  input  logic signed [W-1:0]    b_im,
  input  logic        [TAGW-1:0] tag_in,
  output logic                   rdy,
  output logic signed [W-1:0]    result_re,
  output logic signed [W-1:0]    result_im,
  output logic        [TAGW-1:0] tag_out,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;

  logic                r_rfd;
  logic [CMUL_LAT-1:0] r_vld;
  logic                r_rdy;
  logic                r_ovf;
  logic                w_accept;

  logic signed [W-1:0]  r_ar, r_ai, r_br, r_bi;
  logic                 r_conj1;
  logic [TAGW-1:0]      r_tag1;

  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic                 r_conj2;
  logic [TAGW-1:0]      r_tag2;

  logic signed [SW-1:0] r_sum_re, r_sum_im;
  logic [TAGW-1:0]      r_tag3;

  logic signed [W-1:0]  w_sat_re, w_sat_im;
  logic                 w_ovf_re, w_ovf_im;
  logic signed [W-1:0]  r_s4_re, r_s4_im;
  logic                 r_s4_ovf;
  logic [TAGW-1:0]      r_tag4;

  logic signed [W-1:0]  r_res_re, r_res_im;
  logic [TAGW-1:0]      r_res_tag;

  assign w_accept      = operation_nd & r_rfd;
  assign operation_rfd = r_rfd;
  assign rdy           = r_rdy;
  assign ovf           = r_ovf;
  assign result_re     = r_res_re;
  assign result_im     = r_res_im;
  assign tag_out       = r_res_tag;

  // Valid pipe, ready and the sticky flag; a new overflow beats a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rfd <= 1'b0;
      r_vld <= '0;
      r_rdy <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_rfd <= 1'b1;
      r_vld <= {r_vld[CMUL_LAT-2:0], w_accept};
      r_rdy <= r_vld[CMUL_LAT-1];
      if (r_vld[CMUL_LAT-1] && r_s4_ovf) r_ovf <= 1'b1;
      else if (ovf_clr)                  r_ovf <= 1'b0;
    end
  end

  // S1: operand capture.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ar    <= a_re;
      r_ai    <= a_im;
      r_br    <= b_re;
      r_bi    <= b_im;
      r_conj1 <= conj_b;
      r_tag1  <= tag_in;
    end
  end

  // S2: the four partial products.
  always_ff @(posedge clk) begin
    if (r_vld[0]) begin
      r_p_rr  <= PW'(r_ar) * PW'(r_br);
      r_p_ii  <= PW'(r_ai) * PW'(r_bi);
      r_p_ri  <= PW'(r_ar) * PW'(r_bi);
      r_p_ir  <= PW'(r_ai) * PW'(r_br);
      r_conj2 <= r_conj1;
      r_tag2  <= r_tag1;
    end
  end

  // S3: one extra bit absorbs the (-1)*(-1) + (-1)*(-1) corner.
  always_ff @(posedge clk) begin
    if (r_vld[1]) begin
      r_sum_re <= r_conj2 ? (SW'(r_p_rr) + SW'(r_p_ii)) : (SW'(r_p_rr) - SW'(r_p_ii));
      r_sum_im <= r_conj2 ? (SW'(r_p_ir) - SW'(r_p_ri)) : (SW'(r_p_ri) + SW'(r_p_ir));
      r_tag3   <= r_tag2;
    end
  end

  sat_round #(.W(W), .RND(RND)) u_sat_re (
    .i_sum (r_sum_re),
    .o_val (w_sat_re),
    .o_ovf (w_ovf_re)
  );

  sat_round #(.W(W), .RND(RND)) u_sat_im (
    .i_sum (r_sum_im),
    .o_val (w_sat_im),
    .o_ovf (w_ovf_im)
  );

  // S4: scaled and clamped components.
  always_ff @(posedge clk) begin
    if (r_vld[2]) begin
      r_s4_re  <= w_sat_re;
      r_s4_im  <= w_sat_im;
      r_s4_ovf <= w_ovf_re | w_ovf_im;
      r_tag4   <= r_tag3;
    end
  end

  // Output register holds its value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_re  <= '0;
      r_res_im  <= '0;
      r_res_tag <= '0;
    end else if (r_vld[CMUL_LAT-1]) begin
      r_res_re  <= r_s4_re;
      r_res_im  <= r_s4_im;
      r_res_tag <= r_tag4;
    end
  end

endmodule

// File: tb/tb_cmul_pipe.sv
// Scoreboard bench for cmul_pipe: expected results queued at drive time, checked as rdy pulses arrive.
`timescale 1ns/1ps
module tb_cmul_pipe;

  localparam int W    = 20;
  localparam int TAGW = 8;

  typedef struct {
    logic [W-1:0]    re;
    logic [W-1:0]    im;
    logic [TAGW-1:0] tag;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            operation_nd = 1'b0;
  logic            conj_b = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [W-1:0]    a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [TAGW-1:0] tag_in = '0;

  logic            operation_rfd, rdy, ovf;
  logic [W-1:0]    result_re, result_im;
  logic [TAGW-1:0] tag_out;

  logic            t_rfd, t_rdy, t_ovf;
  logic [W-1:0]    t_re, t_im;
  logic [TAGW-1:0] t_tag;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmul_pipe #(.W(W), .TAGW(TAGW), .RND(1'b1)) u_dut (
    .clk(clk), .rst(rst), .operation_nd(operation_nd), .operation_rfd(operation_rfd),
    .conj_b(conj_b), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tag_in(tag_in),
    .rdy(rdy), .result_re(result_re), .result_im(result_im), .tag_out(tag_out),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  cmul_pipe #(.W(W), .TAGW(TAGW), .RND(1'b0)) u_dut_trunc (
    .clk(clk), .rst(rst), .operation_nd(operation_nd), .operation_rfd(t_rfd),
    .conj_b(conj_b), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tag_in(tag_in),
    .rdy(t_rdy), .result_re(t_re), .result_im(t_im), .tag_out(t_tag),
    .ovf(t_ovf), .ovf_clr(ovf_clr)
  );

  function automatic logic [W-1:0] scale(input longint s, input bit rnd);
    longint v, hi, lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    v  = rnd ? (s + (longint'(1) <<< (W-2))) : s;
    v  = v >>> (W-1);
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nd, input logic cj, input logic [W-1:0] ar, input logic [W-1:0] ai,
                       input logic [W-1:0] br, input logic [W-1:0] bi, input logic [TAGW-1:0] tg);
    tick();
    operation_nd = nd; conj_b = cj;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; tag_in = tg;
  endtask

  // Sample driven this cycle is taken on the next edge and shows rdy four edges later.
  task automatic push(input logic [W-1:0] re, input logic [W-1:0] im, input logic [TAGW-1:0] tg);
    exp_t e;
    e.re = re; e.im = im; e.tag = tg; e.cyc = cyc + 5;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (operation_rfd !== 1'b0 || rdy !== 1'b0 || ovf !== 1'b0 || result_re !== '0 ||
          result_im !== '0 || tag_out !== '0) begin
        miscompares++;
        $display("FAIL reset_state rfd=%b rdy=%b ovf=%b re=%h im=%h tag=%h, want all zero",
                 operation_rfd, rdy, ovf, result_re, result_im, tag_out);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (operation_rfd !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_rfd got %b want 1", operation_rfd);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    drive(1, 0, 20'h78000, 20'h0, 20'h78000, 20'h0, 8'h11);
    push(20'h70800, 20'h0, 8'h11);
    for (int i = 0; i < 8; i++) begin
      tick(); operation_nd = 0;
      if (rdy) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL basic_spurious_rdy cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if (result_re !== e.re || result_im !== e.im || tag_out !== e.tag || cyc != e.cyc || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL basic got re=%h im=%h tag=%h ovf=%b cyc=%0d want re=%h im=%h tag=%h ovf=0 cyc=%0d",
                     result_re, result_im, tag_out, ovf, cyc, e.re, e.im, e.tag, e.cyc);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL basic_missing_rdy pending=%0d", sb.size()); sb.delete();
    end
  endtask

  task automatic test_conj_stream();
    exp_t e;
    drive(1, 0, 20'h40000, 20'h40000, 20'h00000, 20'h7FFFF, 8'h21);
    push(20'hC0001, 20'h40000, 8'h21);
    drive(1, 1, 20'h40000, 20'h40000, 20'h00000, 20'h7FFFF, 8'h22);
    push(20'h40000, 20'hC0001, 8'h22);
    for (int i = 0; i < 8; i++) begin
      tick(); operation_nd = 0;
      if (rdy) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL conj_spurious_rdy cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if (result_re !== e.re || result_im !== e.im || tag_out !== e.tag || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL conj_stream got re=%h im=%h tag=%h cyc=%0d want re=%h im=%h tag=%h cyc=%0d",
                     result_re, result_im, tag_out, cyc, e.re, e.im, e.tag, e.cyc);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL conj_missing_rdy pending=%0d", sb.size()); sb.delete();
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic want_ovf;
    // Pass 0: plain overflow; pass 1: clean sample after a clear; pass 2: clear on the overflow edge.
    for (int p = 0; p < 3; p++) begin
      if (p == 1) begin
        drive(1, 0, 20'h78000, 20'h0, 20'h78000, 20'h0, 8'h32);
        push(20'h70800, 20'h0, 8'h32);
        want_ovf = 1'b0;
      end else begin
        drive(1, 0, 20'h80000, 20'h80000, 20'h80000, 20'h80000, 8'(8'h31 + p));
        push(20'h0, 20'h7FFFF, 8'(8'h31 + p));
        want_ovf = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        tick(); operation_nd = 0;
        ovf_clr = (p == 2 && i == 3);
        if (rdy) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++; $display("FAIL sat_spurious_rdy cyc=%0d", cyc);
          end else begin
            e = sb.pop_front();
            if (result_re !== e.re || result_im !== e.im || tag_out !== e.tag || cyc != e.cyc || ovf !== want_ovf) begin
              miscompares++;
              $display("FAIL sat_pass%0d got re=%h im=%h tag=%h ovf=%b cyc=%0d want re=%h im=%h tag=%h ovf=%b cyc=%0d",
                       p, result_re, result_im, tag_out, ovf, cyc, e.re, e.im, e.tag, want_ovf, e.cyc);
            end
          end
        end
      end
      vectors++;
      if (sb.size() != 0 || ovf !== want_ovf) begin
        miscompares++;
        $display("FAIL sat_sticky_pass%0d ovf=%b want %b pending=%0d", p, ovf, want_ovf, sb.size());
        sb.delete();
      end
      tick(); ovf_clr = 1'b1;
      tick(); ovf_clr = 1'b0;
      vectors++;
      if (ovf !== 1'b0) begin
        miscompares++; $display("FAIL sat_ovf_clr got %b want 0", ovf);
      end
    end
  endtask

  task automatic test_rounding();
    exp_t e;
    logic [W-1:0] t_want [2];
    int ti = 0;
    t_want[0] = 20'h00000;
    t_want[1] = 20'hFFFFF;
    drive(1, 0, 20'h00001, 20'h0, 20'h40000, 20'h0, 8'h41);
    push(20'h00001, 20'h0, 8'h41);
    drive(1, 0, 20'hFFFFF, 20'h0, 20'h40000, 20'h0, 8'h42);
    push(20'h00000, 20'h0, 8'h42);
    for (int i = 0; i < 8; i++) begin
      tick(); operation_nd = 0;
      if (rdy) begin
        vectors++;
        if (sb.size() == 0 || ti > 1) begin
          miscompares++; $display("FAIL round_spurious_rdy cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if (result_re !== e.re || result_im !== e.im || tag_out !== e.tag || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL round_rnd1 got re=%h im=%h tag=%h cyc=%0d want re=%h im=%h tag=%h cyc=%0d",
                     result_re, result_im, tag_out, cyc, e.re, e.im, e.tag, e.cyc);
          end
          vectors++;
          if (t_rdy !== 1'b1 || t_re !== t_want[ti] || t_im !== 20'h0 || t_tag !== e.tag) begin
            miscompares++;
            $display("FAIL round_rnd0 got rdy=%b re=%h im=%h tag=%h want rdy=1 re=%h im=0 tag=%h",
                     t_rdy, t_re, t_im, t_tag, t_want[ti], e.tag);
          end
          ti++;
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL round_missing_rdy pending=%0d", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_midflight();
    drive(1, 0, 20'h78000, 20'h0, 20'h78000, 20'h0, 8'h61);
    drive(1, 0, 20'h40000, 20'h0, 20'h40000, 20'h0, 8'h62);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    operation_nd = 1'b1; tag_in = 8'h63;
    vectors++;
    if (operation_rfd !== 1'b0 || rdy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_in_reset rfd=%b rdy=%b want 0 0", operation_rfd, rdy);
    end
    tick();
    operation_nd = 1'b0;
    vectors++;
    if (operation_rfd !== 1'b1) begin
      miscompares++; $display("FAIL midrst_rfd_after got %b want 1", operation_rfd);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (rdy !== 1'b0 || result_re !== '0 || result_im !== '0 || tag_out !== '0 || ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_idle cyc=%0d rdy=%b re=%h im=%h tag=%h ovf=%b want all zero",
                 cyc, rdy, result_re, result_im, tag_out, ovf);
      end
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    logic [4:0] pat = 5'b01101;
    logic [W-1:0] ar, ai, br, bi;
    logic cj;
    longint rr, ii, ri, ir;
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 5; k++) begin
        ar = W'($urandom); ai = W'($urandom); br = W'($urandom); bi = W'($urandom);
        cj = 1'($urandom);
        drive(pat[4-k], cj, ar, ai, br, bi, 8'(8'h50 + rep * 8 + k));
        if (pat[4-k]) begin
          rr = longint'($signed(ar)) * longint'($signed(br));
          ii = longint'($signed(ai)) * longint'($signed(bi));
          ri = longint'($signed(ar)) * longint'($signed(bi));
          ir = longint'($signed(ai)) * longint'($signed(br));
          push(scale(cj ? rr + ii : rr - ii, 1'b1), scale(cj ? ir - ri : ri + ir, 1'b1),
               8'(8'h50 + rep * 8 + k));
        end
      end
      for (int i = 0; i < 8; i++) begin
        tick(); operation_nd = 0;
        if (rdy) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++; $display("FAIL bubble_spurious_rdy cyc=%0d", cyc);
          end else begin
            e = sb.pop_front();
            if (result_re !== e.re || result_im !== e.im || tag_out !== e.tag || cyc != e.cyc) begin
              miscompares++;
              $display("FAIL bubble got re=%h im=%h tag=%h cyc=%0d want re=%h im=%h tag=%h cyc=%0d",
                       result_re, result_im, tag_out, cyc, e.re, e.im, e.tag, e.cyc);
            end
          end
        end
      end
      vectors++;
      if (sb.size() != 0) begin
        miscompares++; $display("FAIL bubble_missing_rdy pending=%0d", sb.size()); sb.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conj_stream();
    test_saturation();
    test_rounding();
    test_reset_midflight();
    test_bubbles();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmul_pipe.md
Name: cmul_pipe

Overview:
- Parametrised, fully pipelined signed fixed-point complex multiplier; the next generation of the team's 20-bit real MUL core.
- Used as the FFT butterfly twiddle multiplier.
- Keeps the operation_nd / operation_rfd / rdy handshake and adds:
  - complex operands and a conjugate mode
  - selectable rounding and saturation
  - a sticky overflow flag
  - a tag that travels alongside the data

Parameters:
- W, 20, width of each real/imag component, signed Q1.(W-1).
- TAGW, 8, width of the sideband tag (e.g. FFT sample index).
- RND, 1, 1 = round-half-up, 0 = truncate.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- operation_nd  in  1  input sample valid.
- operation_rfd  out  1  ready for data.
- conj_b  in  1  when 1, multiply by conj(b); sampled with operation_nd.
- a_re, a_im  in  W each  operand a.
- b_re, b_im  in  W each  operand b (twiddle).
- tag_in  in  TAGW  sideband, returned unchanged with the result.
- rdy  out  1  result valid.
- result_re, result_im  out  W each  product.
- tag_out  out  TAGW  tag belonging to the result.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset: one clock, clk; reset rst is synchronous and active-high.
- While rst=1, on each clk edge: valid pipe, rdy, result_re/im, tag_out and ovf all go to 0; operation_rfd=0.
- operation_rfd is 1 from the first cycle after rst deasserts. There is no backpressure: one sample is accepted every cycle.
- Input is accepted on a clk edge where operation_nd=1 and operation_rfd=1. If operation_nd=1 while rfd=0, the sample is dropped.
- Fixed latency of 4 cycles. A sample accepted at edge N gives rdy=1 with its data for the cycle after edge N+4.
- Pipeline stages:
  - S1: register operands, conj_b and tag.
  - S2: four signed W×W products (2W bits each).
  - S3: sum and difference to 2W+1 bits. Normal: re = ar·br − ai·bi, im = ar·bi + ai·br. With conj_b=1: re = ar·br + ai·bi, im = ai·br − ar·bi.
  - S4: scale, round, saturate, register outputs.
- Scaling: result = sum >> (W-1), arithmetic shift. When RND=1, add 2^(W-2) before the shift.
- Saturation: clamp to [−2^(W-1), 2^(W-1)−1]. Re and im saturate independently.
- ovf: set on the S4 edge whenever either component clamps. It stays 1 until ovf_clr=1 or rst. If ovf_clr=1 and a new overflow arrive on the same edge, set wins and ovf=1.
- Valid pipe is a 4-bit shift register. Bubbles (operation_nd=0) propagate as rdy=0.
- When rdy=0, result_re/im/tag_out hold their last values.
- Reset mid-operation clears all in-flight valids. No result from before reset ever appears, and the first post-reset rdy comes no earlier than 4 cycles after the first accepted sample.
- Back-to-back input gives back-to-back rdy, in order, with no reordering.

Decomposition:
- Package cmul_pkg holds:
  - the latency constant CMUL_LAT=4
  - a function for the saturating round/shift of a (2W+1)-bit value to W bits
  - the complex struct typedef used by FFT stages.
- Sub-module sat_round (one instance per component): combinational scale/round/clamp that outputs the value plus an overflow bit. It is registered by the parent in S4.

Test Plan:
1. Basic and latency, W=20, RND=1:
   - Stimulus: a=0x78000+j0, b=0x78000+j0, tag 0x11.
   - Required: rdy exactly 4 cycles after acceptance; result_re=0x70800, result_im=0, tag_out=0x11, ovf=0.
2. Complex, conj and streaming:
   - Stimulus: a=0x40000+j0x40000 (0.5+0.5j), b=0x00000+j0x7FFFF, back-to-back with conj_b=0 then 1.
   - Required (within 1 LSB of ideal): result ≈ −0x3FFFF+j0x3FFFF, then 0x3FFFF−j0x3FFFF; both on consecutive rdy cycles, tags in order.
3. Saturation and sticky flag:
   - Stimulus: a=b=0x80000+j0x80000.
   - Required: result_re=0, result_im=0x7FFFF clamped, ovf=1.
   - Stimulus: then ovf_clr=1 for one cycle, then a normal input.
   - Required: ovf=0.
4. Rounding mode:
   - Stimulus: a=0x00001, b=0x40000 (1 LSB × 0.5).
   - Required: RND=1 gives 0x00001; RND=0 build gives 0x00000.
5. Reset mid-flight:
   - Stimulus: accept 3 samples, assert rst for 1 cycle at the 2nd cycle, then idle.
   - Required: rdy stays 0, outputs 0; rfd=0 during reset, 1 after.
6. Bubbles:
   - Stimulus: operation_nd pattern 1,0,1,1,0 with random operands.
   - Required: rdy pattern 1,0,1,1,0 delayed by 4 cycles; data matches the reference model bit-exactly.
